// File: rtl/des_seq_pkg.sv
// rtl/des_seq_pkg.sv - shared types and constants for the DES block sequencer
package des_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        FILL,
        LAUNCH,
        WAIT_DES,
        HOLD,
        SEND
    } seq_state_t;

    localparam logic MODE_ENC     = 1'b0;
    localparam logic MODE_DEC     = 1'b1;
    localparam int   CMD_MODE_BIT = 0;
    localparam int   BLOCK_W      = 64;

endpackage

// File: rtl/des_block_sequencer_block_packer.sv
// rtl/des_block_sequencer_block_packer.sv - MSB-first byte packer with saturating byte count
module block_packer
    import des_seq_pkg::*;
#(
    parameter int BLOCK_BYTES = 8
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift,
    input  logic [7:0]         byte_in,
    output logic [BLOCK_W-1:0] block,
    output logic               last,
    output logic               any_bytes
);

    localparam int               CNT_W   = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLOCK_BYTES - 1);

    logic [CNT_W-1:0] count;

    // New bytes enter at the LSB end so the first byte lands in the top byte lane.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            block <= '0;
            count <= '0;
        end else if (shift) begin
            block <= {block[BLOCK_W-9:0], byte_in};
            if (count != CNT_MAX) begin
                count <= count + 1'b1;
            end
        end
    end

    assign last      = (count == CNT_MAX);
    assign any_bytes = (count != '0);

endmodule

// File: rtl/des_block_sequencer.sv
// rtl/des_block_sequencer.sv - I2C-to-3DES block sequencer; DES_SEQ_BLK_COUNT_EN enables blk_count
module des_block_sequencer
    import des_seq_pkg::*;
#(
    parameter int BLOCK_BYTES    = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TMR_W          = 13
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               byte_valid,
    input  logic [7:0]         byte_in,
    input  logic               i2c_start,
    input  logic               i2c_stop,
    input  logic               i2c_rw,
    output logic               des_start,
    output logic               des_mode,
    output logic [BLOCK_W-1:0] des_in,
    input  logic               des_done,
    input  logic [BLOCK_W-1:0] des_out,
    output logic [BLOCK_W-1:0] write_data,
    output logic               output_ready,
    output logic               data_ready,
    output logic               err_overrun,
    output logic               err_short,
    output logic               err_timeout,
    output logic [15:0]        blk_count
);

    seq_state_t       state, state_nxt;
    logic             abort, start_wr, wdog_exp;
    logic             pk_clr, pk_shift, pk_last, pk_any;
    logic [TMR_W-1:0] wdog;

    assign abort    = i2c_start | i2c_stop;
    assign start_wr = i2c_start & ~i2c_rw;
    assign wdog_exp = (wdog == TMR_W'(TIMEOUT_CYCLES - 1));

    block_packer #(
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .shift     (pk_shift),
        .byte_in   (byte_in),
        .block     (des_in),
        .last      (pk_last),
        .any_bytes (pk_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Start/stop outrank a same-cycle byte; a write start always re-enters CMD.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_wr) state_nxt = CMD;
            CMD: begin
                if (start_wr)        state_nxt = CMD;
                else if (abort)      state_nxt = IDLE;
                else if (byte_valid) state_nxt = FILL;
            end
            FILL: begin
                if (start_wr)                   state_nxt = CMD;
                else if (abort)                 state_nxt = IDLE;
                else if (byte_valid && pk_last) state_nxt = LAUNCH;
            end
            LAUNCH:   state_nxt = WAIT_DES;
            WAIT_DES: begin
                if (des_done)      state_nxt = HOLD;
                else if (wdog_exp) state_nxt = IDLE;
            end
            HOLD:     if (i2c_start) state_nxt = i2c_rw ? SEND : CMD;
            SEND: begin
                if (start_wr)   state_nxt = CMD;
                else if (abort) state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        des_start   = (state == LAUNCH);
        pk_clr      = (state == CMD)  && byte_valid && !abort;
        pk_shift    = (state == FILL) && byte_valid && !abort;
        err_short   = (state == FILL) && abort && pk_any;
        err_timeout = (state == WAIT_DES) && !des_done && wdog_exp;
        err_overrun = 1'b0;
        if (state == LAUNCH || state == WAIT_DES || state == HOLD || state == SEND) begin
            err_overrun = byte_valid && !abort;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            des_mode     <= MODE_ENC;
            write_data   <= '0;
            data_ready   <= 1'b0;
            output_ready <= 1'b0;
            wdog         <= '0;
        end else begin
            output_ready <= (state == HOLD) && i2c_start && i2c_rw;
            if (pk_clr) begin
                des_mode <= byte_in[CMD_MODE_BIT] ? MODE_DEC : MODE_ENC;
            end
            if (state == LAUNCH) begin
                wdog <= '0;
            end else if (state == WAIT_DES) begin
                wdog <= wdog + 1'b1;
            end
            if (state == WAIT_DES && des_done) begin
                write_data <= des_out;
                data_ready <= 1'b1;
            end else if ((state == HOLD && start_wr) || (state == SEND && abort)) begin
                data_ready <= 1'b0;
            end
        end
    end

`ifdef DES_SEQ_BLK_COUNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= 16'h0000;
        end else if (state == WAIT_DES && des_done) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign blk_count = blk_cnt_q;
`else
    assign blk_count = 16'h0000;
`endif

endmodule

// File: tb/tb_des_block_sequencer.sv
// tb/tb_des_block_sequencer.sv - directed self-checking bench for des_block_sequencer
module tb_des_block_sequencer;
    import des_seq_pkg::*;

    localparam int TIMEOUT = 4096;
`ifdef DES_SEQ_BLK_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        i2c_start = 1'b0;
    logic        i2c_stop = 1'b0;
    logic        i2c_rw = 1'b0;
    logic        des_done = 1'b0;
    logic [63:0] des_out = 64'h0;
    logic        des_start, des_mode, output_ready, data_ready;
    logic        err_overrun, err_short, err_timeout;
    logic [63:0] des_in, write_data;
    logic [15:0] blk_count;

    int n_vec = 0;
    int n_bad = 0;
    int c_start = 0, c_ordy = 0, c_ovr = 0, c_short = 0, c_to = 0;
    int b_start, b_ordy, b_ovr, b_short, b_to, k_to;

    des_block_sequencer #(
        .BLOCK_BYTES    (8),
        .TIMEOUT_CYCLES (TIMEOUT),
        .TMR_W          (13)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .byte_in      (byte_in),
        .i2c_start    (i2c_start),
        .i2c_stop     (i2c_stop),
        .i2c_rw       (i2c_rw),
        .des_start    (des_start),
        .des_mode     (des_mode),
        .des_in       (des_in),
        .des_done     (des_done),
        .des_out      (des_out),
        .write_data   (write_data),
        .output_ready (output_ready),
        .data_ready   (data_ready),
        .err_overrun  (err_overrun),
        .err_short    (err_short),
        .err_timeout  (err_timeout),
        .blk_count    (blk_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (des_start)    c_start++;
        if (output_ready) c_ordy++;
        if (err_overrun)  c_ovr++;
        if (err_short)    c_short++;
        if (err_timeout)  c_to++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] blk_exp(input int n);
        return CNT_EN ? 64'(n) : 64'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic do_start(input logic rw);
        i2c_start = 1'b1;
        i2c_rw    = rw;
        tick();
        i2c_start = 1'b0;
        i2c_rw    = 1'b0;
    endtask

    task automatic do_stop();
        i2c_stop = 1'b1;
        tick();
        i2c_stop = 1'b0;
    endtask

    task automatic write_block(input logic [7:0] cmd, input logic [63:0] data);
        do_start(1'b0);
        send_byte(cmd);
        for (int i = 7; i >= 0; i--) send_byte(data[i*8 +: 8]);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_des_in"},       des_in,       64'h0);
        check({pfx, "_write_data"},   write_data,   64'h0);
        check({pfx, "_data_ready"},   data_ready,   64'h0);
        check({pfx, "_des_mode"},     des_mode,     64'h0);
        check({pfx, "_blk_count"},    blk_count,    64'h0);
        check({pfx, "_des_start"},    des_start,    64'h0);
        check({pfx, "_output_ready"}, output_ready, 64'h0);
    endtask

    initial begin
        repeat (3) tick();
        check_reset_values("rst");
        rst = 1'b0;
        tick();

        // Basic encrypt block
        b_start = c_start;
        write_block(8'h00, 64'h0102030405060708);
        check("t1_des_start_lat1", des_start, 64'h1);
        check("t1_des_in", des_in, 64'h0102030405060708);
        check("t1_des_mode", des_mode, 64'(MODE_ENC));
        tick();
        check("t1_des_start_one_cycle", des_start, 64'h0);
        repeat (9) tick();
        des_done = 1'b1;
        des_out  = 64'hA5A5_5A5A_0F0F_F0F0;
        tick();
        des_done = 1'b0;
        des_out  = 64'h0;
        check("t1_data_ready", data_ready, 64'h1);
        check("t1_write_data", write_data, 64'hA5A5_5A5A_0F0F_F0F0);
        check("t1_blk_count", blk_count, blk_exp(1));
        check("t1_start_pulses", 64'(c_start - b_start), 64'h1);

        // Read out
        b_ordy = c_ordy;
        do_start(1'b1);
        check("t2_output_ready", output_ready, 64'h1);
        tick();
        check("t2_output_ready_low", output_ready, 64'h0);
        check("t2_ordy_pulses", 64'(c_ordy - b_ordy), 64'h1);
        check("t2_data_ready_send", data_ready, 64'h1);
        do_stop();
        check("t2_data_ready_clr", data_ready, 64'h0);
        b_ovr = c_ovr;
        send_byte(8'hFF);
        check("t2_idle_no_overrun", 64'(c_ovr - b_ovr), 64'h0);

        // Short block then decrypt block
        b_short = c_short;
        b_start = c_start;
        do_start(1'b0);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        do_stop();
        check("t3_err_short", 64'(c_short - b_short), 64'h1);
        check("t3_no_launch", 64'(c_start - b_start), 64'h0);
        write_block(8'h01, 64'h1122334455667788);
        check("t3_des_mode", des_mode, 64'(MODE_DEC));
        check("t3_des_in", des_in, 64'h1122334455667788);
        repeat (2) tick();
        des_done = 1'b1;
        des_out  = 64'h0123456789ABCDEF;
        tick();
        des_done = 1'b0;
        des_out  = 64'h0;
        check("t3_write_data", write_data, 64'h0123456789ABCDEF);
        check("t3_blk_count", blk_count, blk_exp(2));
        do_start(1'b0);
        check("t3_discard", data_ready, 64'h0);
        b_short = c_short;
        do_stop();
        check("t3_cmd_stop_no_short", 64'(c_short - b_short), 64'h0);

        // Watchdog timeout with an overrun byte
        b_ovr = c_ovr;
        b_to  = c_to;
        k_to  = -1;
        write_block(8'h00, 64'hDEADBEEFCAFEF00D);
        for (int k = 1; k <= TIMEOUT + 10; k++) begin
            byte_valid = (k == 5);
            byte_in    = 8'h77;
            tick();
            byte_valid = 1'b0;
            if (err_timeout) begin
                k_to = k;
                break;
            end
        end
        check("t4_timeout_cycle", 64'(k_to), 64'(TIMEOUT));
        tick();
        check("t4_timeout_pulses", 64'(c_to - b_to), 64'h1);
        check("t4_overrun", 64'(c_ovr - b_ovr), 64'h1);
        check("t4_data_ready", data_ready, 64'h0);
        check("t4_write_data_kept", write_data, 64'h0123456789ABCDEF);
        check("t4_blk_count", blk_count, blk_exp(2));

        // Byte and stop in the same cycle
        b_ovr   = c_ovr;
        b_short = c_short;
        do_start(1'b0);
        send_byte(8'h00);
        send_byte(8'hC1);
        send_byte(8'hC2);
        byte_valid = 1'b1;
        byte_in    = 8'hC3;
        i2c_stop   = 1'b1;
        #1;
        check("t5_err_short_comb", err_short, 64'h1);
        check("t5_no_overrun_comb", err_overrun, 64'h0);
        tick();
        byte_valid = 1'b0;
        i2c_stop   = 1'b0;
        check("t5_byte_dropped", des_in, 64'h0000_0000_0000_C1C2);
        check("t5_short_pulses", 64'(c_short - b_short), 64'h1);
        check("t5_overrun_pulses", 64'(c_ovr - b_ovr), 64'h0);

        // Reset during WAIT_DES, late des_done ignored
        write_block(8'h01, 64'h5555_6666_7777_8888);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        des_done = 1'b1;
        des_out  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        des_done = 1'b0;
        des_out  = 64'h0;
        check_reset_values("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
